// File: rtl/shift_add_multiplier.sv
// Sequential signed WIDTH x WIDTH add/shift multiplier on an X:A:B chain.
// Ports: Clk, Reset (sync, high), Run, Multiplicand, Multiplier in;
//   Busy, Done, X, Aval, Bval, Product out. Optional: MULT_ZERO_SKIP_EN.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic               Busy,
  output logic               Done,
  output logic               X,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             x;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   xa;
  logic [WIDTH:0]   sx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [CW-1:0]    cnt_nx;

  // X always mirrors the true sign of the A accumulator, so {X,A}
  // is the sign-extended A at WIDTH+1 bits.
  assign xa     = {x, a};
  assign sx     = {s[WIDTH-1], s};
  assign sum    = xa + sx;
  assign diff   = xa - sx;
  assign cnt_nx = count + 1'b1;

`ifdef MULT_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (Multiplicand == '0) || (Multiplier == '0);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      s      <= '0;
      a      <= '0;
      b      <= '0;
      x      <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Run) begin
            s     <= Multiplicand;
            a     <= '0;
            x     <= 1'b0;
            count <= '0;
`ifdef MULT_ZERO_SKIP_EN
            if (zero_op) begin
              b      <= '0;
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              b      <= Multiplier;
              state  <= ADD;
              busy_q <= 1'b1;
            end
`else
            b      <= Multiplier;
            state  <= ADD;
            busy_q <= 1'b1;
`endif
          end
        end
        ADD: begin
          // Top multiplier bit carries negative weight.
          if (b[0]) begin
            if (count == LAST) {x, a} <= diff;
            else               {x, a} <= sum;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          a     <= {x, a[WIDTH-1:1]};
          b     <= {a[0], b[WIDTH-1:1]};
          count <= cnt_nx;
          if (cnt_nx == FULL) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign X       = x;
  assign Aval    = a;
  assign Bval    = b;
  assign Product = {a, b};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=8 and WIDTH=4).
// Vector table plus hand sequences for reset, hold-run and busy cases.
module tb_shift_add_multiplier;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic [7:0]  Multiplicand;
  logic [7:0]  Multiplier;
  logic        Busy, Done, X;
  logic [7:0]  Aval, Bval;
  logic [15:0] Product;

  logic        run4;
  logic [3:0]  mc4, mp4;
  logic        busy4, done4, x4;
  logic [3:0]  aval4, bval4;
  logic [7:0]  product4;

  always #5 Clk = ~Clk;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .X(X),
    .Aval(Aval), .Bval(Bval), .Product(Product)
  );

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Run(run4),
    .Multiplicand(mc4), .Multiplier(mp4),
    .Busy(busy4), .Done(done4), .X(x4),
    .Aval(aval4), .Bval(bval4), .Product(product4)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        x;
  } vec_t;

  vec_t vecs[11];

  // Starts at a negedge, ends at the negedge where Done was seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p, output logic xo,
                       output int lat, output int busyc);
    lat   = 0;
    busyc = 0;
    Run          = 1'b1;
    Multiplicand = a;
    Multiplier   = b;
    @(negedge Clk);
    Run = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (Busy) busyc++;
      if (Done) begin
        lat = i;
        break;
      end
      @(negedge Clk);
    end
    p  = Product;
    xo = X;
  endtask

  initial begin
    logic [15:0] p;
    logic        xo;
    int          lat, busyc, exp_lat, exp_busy;
    int          npulse, ndone;
    int          dpos[4];
    logic [15:0] dprod[4];

    vecs[0]  = '{8'd7,   8'hFD, 16'hFFEB, 1'b1};
    vecs[1]  = '{8'h80,  8'h80, 16'h4000, 1'b0};
    vecs[2]  = '{8'hFF,  8'hFF, 16'h0001, 1'b0};
    vecs[3]  = '{8'd127, 8'h80, 16'hC080, 1'b1};
    vecs[4]  = '{8'd0,   8'd5,  16'h0000, 1'b0};
    vecs[5]  = '{8'd2,   8'd3,  16'h0006, 1'b0};
    vecs[6]  = '{8'hFB,  8'd6,  16'hFFE2, 1'b1};
    vecs[7]  = '{8'd100, 8'd100, 16'h2710, 1'b0};
    vecs[8]  = '{8'h80,  8'd127, 16'hC080, 1'b1};
    vecs[9]  = '{8'd1,   8'h80, 16'hFF80, 1'b1};
    vecs[10] = '{8'hFB,  8'd0,  16'h0000, 1'b0};

    Reset = 1'b1;
    Run = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    run4 = 1'b0;
    mc4 = '0;
    mp4 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_prod", 32'(Product), 32'd0);
    chk("rst_x", 32'(X), 32'd0);
    chk("rst_prod4", 32'(product4), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int v = 0; v < 11; v++) begin
`ifdef MULT_ZERO_SKIP_EN
      if (vecs[v].a == 0 || vecs[v].b == 0) begin
        exp_lat = 1;
        exp_busy = 0;
      end else begin
        exp_lat = 17;
        exp_busy = 16;
      end
`else
      exp_lat = 17;
      exp_busy = 16;
`endif
      do_op(vecs[v].a, vecs[v].b, p, xo, lat, busyc);
      chk($sformatf("v%0d_prod", v), 32'(p), 32'(vecs[v].p));
      chk($sformatf("v%0d_x", v), 32'(xo), 32'(vecs[v].x));
      chk($sformatf("v%0d_lat", v), 32'(lat), 32'(exp_lat));
      chk($sformatf("v%0d_busy", v), 32'(busyc), 32'(exp_busy));
      @(negedge Clk);
      chk($sformatf("v%0d_done_low", v), 32'(Done), 32'd0);
      chk($sformatf("v%0d_hold", v), 32'(Product), 32'(vecs[v].p));
    end

    // Reset in the middle of 7 * -3.
    Run = 1'b1;
    Multiplicand = 8'd7;
    Multiplier = 8'hFD;
    @(negedge Clk);
    Run = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_prod", 32'(Product), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    do_op(8'd2, 8'd3, p, xo, lat, busyc);
    chk("after_rst_prod", 32'(p), 32'h0006);
    chk("after_rst_lat", 32'(lat), 32'd17);
    @(negedge Clk);

    // Run held high for 40 cycles.
    npulse = 0;
    Run = 1'b1;
    Multiplicand = 8'd3;
    Multiplier = 8'd4;
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clk);
      if (Done) begin
        if (npulse < 4) begin
          dpos[npulse] = j;
          dprod[npulse] = Product;
        end
        npulse++;
      end
    end
    Run = 1'b0;
    chk("hold_npulse", 32'(npulse), 32'd2);
    chk("hold_pos0", 32'(dpos[0]), 32'd17);
    chk("hold_pos1", 32'(dpos[1]), 32'd35);
    chk("hold_prod0", 32'(dprod[0]), 32'h000C);
    chk("hold_prod1", 32'(dprod[1]), 32'h000C);
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      if (Done) begin
        ndone++;
        break;
      end
    end
    chk("hold_drain", 32'(ndone), 32'd1);
    @(negedge Clk);

    // Operands toggled and Run pulsed while busy.
    Run = 1'b1;
    Multiplicand = 8'd7;
    Multiplier = 8'hFD;
    @(negedge Clk);
    Run = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (Done) begin
        lat = i;
        break;
      end
      Multiplicand = 8'($urandom);
      Multiplier = 8'($urandom);
      Run = (i == 5 || i == 9);
      @(negedge Clk);
    end
    Run = 1'b0;
    chk("tog_lat", 32'(lat), 32'd17);
    chk("tog_prod", 32'(Product), 32'hFFEB);
    chk("tog_x", 32'(X), 32'd1);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    chk("tog_extra_done", 32'(ndone), 32'd0);

    // WIDTH=4: 7 * -8.
    run4 = 1'b1;
    mc4 = 4'h7;
    mp4 = 4'h8;
    @(negedge Clk);
    run4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      if (done4) begin
        lat = i;
        break;
      end
      @(negedge Clk);
    end
    chk("w4_lat", 32'(lat), 32'd9);
    chk("w4_prod", 32'(product4), 32'hC8);
    chk("w4_x", 32'(x4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
